// File: rtl/mmio_peripheral.sv
// Memory-mapped peripheral on the data bus: reloadable timer with IRQ,
// LED and 7-segment registers, and a free-running tick counter.
module mmio_peripheral #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] Read_data,
   output logic        hit,
   output logic        irq,
   output logic [7:0]  leds,
   output logic [11:0] digits
);

   localparam logic [2:0] OFF_TH   = 3'd0;
   localparam logic [2:0] OFF_TL   = 3'd1;
   localparam logic [2:0] OFF_TCON = 3'd2;
   localparam logic [2:0] OFF_LED  = 3'd3;
   localparam logic [2:0] OFF_DIG  = 3'd4;
   localparam logic [2:0] OFF_TICK = 3'd5;

   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic [7:0]  led_q;
   logic [11:0] dig_q;
   logic [31:0] systick;

   logic [2:0] offset;
   logic       in_window;
   logic       wr;
   logic       wr_th;
   logic       wr_tl;
   logic       wr_tcon;
   logic       wr_led;
   logic       wr_dig;
   logic       tl_max;
   logic       tmr_on;

   assign offset    = Address[4:2];
   assign in_window = (Address[31:5] == BASE_ADDR[31:5]);
   assign hit       = in_window && (offset <= OFF_TICK);

   assign wr      = MemWrite && hit;
   assign wr_th   = wr && (offset == OFF_TH);
   assign wr_tl   = wr && (offset == OFF_TL);
   assign wr_tcon = wr && (offset == OFF_TCON);
   assign wr_led  = wr && (offset == OFF_LED);
   assign wr_dig  = wr && (offset == OFF_DIG);

   assign tl_max = (tl == 32'hFFFF_FFFF);
   assign tmr_on = tcon[0];

   always_comb begin
      Read_data = '0;
      if (MemRead && hit) begin
         case (offset)
            OFF_TH:   Read_data = th;
            OFF_TL:   Read_data = tl;
            OFF_TCON: Read_data = {29'd0, tcon};
            OFF_LED:  Read_data = {24'd0, led_q};
            OFF_DIG:  Read_data = {20'd0, dig_q};
            OFF_TICK: Read_data = systick;
            default:  Read_data = '0;
         endcase
      end
   end

   // CPU stores win per register; TH writes never disturb a same-cycle reload.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th      <= '0;
         tl      <= '0;
         tcon    <= '0;
         led_q   <= '0;
         dig_q   <= '0;
         systick <= '0;
      end else begin
         systick <= systick + 32'd1;
         if (wr_th) th <= Write_data;
         if (wr_tl) begin
            tl <= Write_data;
         end else if (tmr_on) begin
            tl <= tl_max ? th : tl + 32'd1;
         end
         if (wr_tcon) begin
            tcon <= Write_data[2:0];
         end else if (tmr_on && tl_max && tcon[1]) begin
            tcon[2] <= 1'b1;
         end
         if (wr_led) led_q <= Write_data[7:0];
         if (wr_dig) dig_q <= Write_data[11:0];
      end
   end

   assign irq    = tcon[1] & tcon[2];
   assign leds   = led_q;
   assign digits = dig_q;

endmodule

// File: tb/tb_mmio_peripheral.sv
// Scoreboard bench for mmio_peripheral: directed stores and loads with
// hand-computed expectations checked by an independent monitor.
`timescale 1ns/1ps
module tb_mmio_peripheral;

   localparam logic [31:0] B = 32'h4000_0000;
   localparam int K_RD = 0, K_HIT = 1, K_IRQ = 2, K_LED = 3, K_DIG = 4;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Read_data;
   logic        hit;
   logic        irq;
   logic [7:0]  leds;
   logic [11:0] digits;

   entry_t q[$];
   event   sample_ev;
   int     n_checks = 0;
   int     n_fail = 0;

   mmio_peripheral #(.BASE_ADDR(B)) dut (
      .clk(clk), .reset(reset), .Address(Address),
      .Write_data(Write_data), .MemRead(MemRead), .MemWrite(MemWrite),
      .Read_data(Read_data), .hit(hit), .irq(irq),
      .leds(leds), .digits(digits)
   );

   always #50 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   always begin
      logic [31:0] act;
      entry_t e;
      @(sample_ev);
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            K_RD:    act = Read_data;
            K_HIT:   act = {31'd0, hit};
            K_IRQ:   act = {31'd0, irq};
            K_LED:   act = {24'd0, leds};
            default: act = {20'd0, digits};
         endcase
         n_checks++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", e.name, act, e.exp);
         end
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      Address    = a;
      Write_data = d;
      MemWrite   = 1'b1;
      MemRead    = 1'b0;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
   endtask

   task automatic chk(input int k, input logic [31:0] a,
                      input logic [31:0] exp, input string nm);
      entry_t e;
      if (k == K_RD || k == K_HIT) begin
         Address = a;
         MemRead = 1'b1;
      end
      #1;
      e.kind = k;
      e.exp  = exp;
      e.name = nm;
      q.push_back(e);
      ->sample_ev;
      #1;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      Address = '0;
      Write_data = '0;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      #1;
      chk(K_RD, B + 32'h8, 32'h0, "rst_tcon");
      chk(K_RD, B + 32'h14, 32'h0, "rst_tick");
      chk(K_LED, 0, 32'h0, "rst_leds");
      chk(K_DIG, 0, 32'h0, "rst_digits");
      chk(K_IRQ, 0, 32'h0, "rst_irq");

      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk(K_RD, B + 32'h14, 32'd100, "tick_100");
      wr(B + 32'h14, 32'h0);
      chk(K_RD, B + 32'h14, 32'd101, "tick_ro");

      wr(B + 32'hC, 32'h0000_01A5);
      chk(K_LED, 0, 32'hA5, "leds_a5");
      chk(K_RD, B + 32'hC, 32'hA5, "led_rd");
      chk(K_RD, B + 32'hF, 32'hA5, "led_rd_unaligned");
      wr(B + 32'h10, 32'hFFFF_F3C0);
      chk(K_DIG, 0, 32'h3C0, "digits_3c0");
      chk(K_RD, B + 32'h10, 32'h3C0, "dig_rd");

      chk(K_HIT, B + 32'h18, 32'h0, "hit_18");
      chk(K_RD, B + 32'h18, 32'h0, "rd_18");
      chk(K_HIT, 32'h1000_0000, 32'h0, "hit_mem");
      chk(K_RD, 32'h1000_0000, 32'h0, "rd_mem");
      chk(K_HIT, B + 32'h14, 32'h1, "hit_14");
      chk(K_HIT, B + 32'h20, 32'h0, "hit_20");
      wr(B + 32'h18, 32'h55);
      wr(32'h1000_000C, 32'h55);
      chk(K_LED, 0, 32'hA5, "miss_leds");
      chk(K_DIG, 0, 32'h3C0, "miss_digits");
      chk(K_RD, B + 32'h0, 32'h0, "miss_th");
      chk(K_RD, B + 32'h4, 32'h0, "miss_tl");
      chk(K_RD, B + 32'h8, 32'h0, "miss_tcon");

      wr(B + 32'h0, 32'hFFFF_FFFC);
      wr(B + 32'h4, 32'hFFFF_FFFD);
      wr(B + 32'h8, 32'h3);
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFD, "tl_e0");
      edge1();
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFE, "tl_e1");
      edge1();
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFF, "tl_e2");
      chk(K_IRQ, 0, 32'h0, "irq_e2");
      edge1();
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFC, "tl_reload");
      chk(K_RD, B + 32'h8, 32'h7, "tcon_ovf");
      chk(K_IRQ, 0, 32'h1, "irq_ovf");
      wr(B + 32'h8, 32'h3);
      chk(K_IRQ, 0, 32'h0, "irq_clr");
      chk(K_RD, B + 32'h8, 32'h3, "tcon_clr");
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFD, "tl_after_clr");
      edge1();
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFE, "tl_counting");

      edge1();
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFF, "tl_pre_coll");
      wr(B + 32'h8, 32'h3);
      chk(K_RD, B + 32'h8, 32'h3, "coll_tcon");
      chk(K_IRQ, 0, 32'h0, "coll_irq");
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFC, "coll_tl");

      repeat (3) edge1();
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFF, "tl_pre_th");
      wr(B + 32'h0, 32'h10);
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFC, "th_coll_tl_old");
      chk(K_RD, B + 32'h0, 32'h10, "th_coll_th");
      chk(K_RD, B + 32'h8, 32'h7, "th_coll_tcon");

      wr(B + 32'h8, 32'h0);
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFD, "tl_at_disable");
      repeat (2) edge1();
      chk(K_RD, B + 32'h4, 32'hFFFF_FFFD, "tl_hold");
      chk(K_IRQ, 0, 32'h0, "irq_disabled");

      wr(B + 32'h4, 32'h1230);
      wr(B + 32'h8, 32'h7);
      chk(K_RD, B + 32'h4, 32'h1230, "tl_start");
      repeat (4) edge1();
      chk(K_RD, B + 32'h4, 32'h1234, "tl_1234");
      chk(K_IRQ, 0, 32'h1, "irq_pre_rst");
      reset = 1'b1;
      chk(K_RD, B + 32'h4, 32'h0, "arst_tl");
      chk(K_RD, B + 32'h8, 32'h0, "arst_tcon");
      chk(K_RD, B + 32'h14, 32'h0, "arst_tick");
      chk(K_LED, 0, 32'h0, "arst_leds");
      chk(K_DIG, 0, 32'h0, "arst_digits");
      chk(K_IRQ, 0, 32'h0, "arst_irq");
      @(negedge clk);
      reset = 1'b0;

      #5;
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
